// File: rtl/lsu.sv
// lsu: byte/half/word load-store unit splitting misaligned accesses into two RAM word accesses
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [29:0] mem_r_addr,
  input  logic [31:0] mem_r_val,
  output logic        mem_w_enable,
  output logic [29:0] mem_w_addr,
  output logic [31:0] mem_w_val,
  output logic [3:0]  mem_byte_en
);
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;
  state_t state, nxt;
  logic we, uns;
  logic [1:0] size, off;
  logic [31:0] addr, wdata, sh, ld;
  logic [63:0] lbuf, data64;
  logic [7:0] mask8;
  assign off = addr[1:0];
  assign mask8 = (size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : 8'h0f) << off;
  assign data64 = {32'b0, wdata} << {off, 3'b0};
  assign sh = 32'(lbuf >> {off, 3'b0});
  assign ld = size == 2'd0 ? {{24{~uns & sh[7]}}, sh[7:0]} :
              size == 2'd1 ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
  always_comb begin
    nxt = state;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_r_addr = '0;
    mem_w_addr = '0;
    mem_w_enable = 1'b0;
    mem_w_val = '0;
    mem_byte_en = '0;
    case (state)
      IDLE: begin
        req_ready = ~rst;
        nxt = req_valid ? ACC1 : IDLE;
      end
      ACC1: begin
        mem_r_addr = addr[31:2];
        mem_w_addr = addr[31:2];
        mem_w_enable = we;
        mem_byte_en = we ? mask8[3:0] : 4'b0;
        mem_w_val = we ? data64[31:0] : 32'b0;
        nxt = |mask8[7:4] ? ACC2 : RESP;
      end
      ACC2: begin
        mem_r_addr = addr[31:2] + 30'd1;
        mem_w_addr = addr[31:2] + 30'd1;
        mem_w_enable = we;
        mem_byte_en = we ? mask8[7:4] : 4'b0;
        mem_w_val = we ? data64[63:32] : 32'b0;
        nxt = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        resp_rdata = we ? 32'b0 : ld;
        nxt = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      we <= 1'b0;
      uns <= 1'b0;
      size <= '0;
      addr <= '0;
      wdata <= '0;
      lbuf <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        we <= req_we;
        uns <= req_unsigned;
        size <= req_size;
        addr <= req_addr;
        wdata <= req_wdata;
      end
      if (state == ACC1 && !we) lbuf[31:0] <= mem_r_val;
      if (state == ACC2 && !we) lbuf[63:32] <= mem_r_val;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vector bench for lsu with a byte-lane RAM model
module tb_lsu;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata, mem_r_val, mem_w_val;
  logic [1:0] req_size = 0;
  logic resp_valid, mem_w_enable;
  logic [29:0] mem_r_addr, mem_w_addr;
  logic [3:0] mem_byte_en;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_r_addr(mem_r_addr), .mem_r_val(mem_r_val),
    .mem_w_enable(mem_w_enable), .mem_w_addr(mem_w_addr), .mem_w_val(mem_w_val), .mem_byte_en(mem_byte_en)
  );

  // sparse RAM: only the handful of word addresses the vectors touch map to distinct slots
  logic [31:0] ram [32];
  logic pl_en = 0;
  logic [29:0] pl_a = 0;
  logic [31:0] pl_d = 0;
  function automatic logic [4:0] h(input logic [29:0] a);
    return {a[29], a[6], a[2:0]};
  endfunction
  assign mem_r_val = ram[h(mem_r_addr)];
  always @(posedge clk) begin
    if (pl_en) ram[h(pl_a)] <= pl_d;
    else if (mem_w_enable)
      for (int b = 0; b < 4; b++)
        if (mem_byte_en[b]) ram[h(mem_w_addr)][8*b +: 8] <= mem_w_val[8*b +: 8];
  end

  typedef struct {
    logic we; logic [31:0] addr; logic [1:0] size; logic uns; logic [31:0] wdata;
    logic split; logic [29:0] a0, a1; logic [3:0] be0, be1; logic [31:0] wv0, wv1, rdata;
  } vec_t;
  vec_t v[18];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic preload(input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1; pl_a = a; pl_d = d;
    @(posedge clk);
    #1 pl_en = 0;
  endtask

  task automatic run(input vec_t t, input string n);
    @(negedge clk);
    req_valid = 1; req_we = t.we; req_addr = t.addr; req_size = t.size;
    req_unsigned = t.uns; req_wdata = t.wdata;
    chk({n, " ready"}, 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 0; req_addr = ~t.addr; req_wdata = ~t.wdata; req_size = ~t.size;
    req_unsigned = ~t.uns; req_we = ~t.we;
    @(negedge clk);
    chk({n, " a0"}, 32'(mem_r_addr), 32'(t.a0));
    chk({n, " wa0"}, 32'(mem_w_addr), 32'(t.a0));
    chk({n, " we0"}, 32'(mem_w_enable), 32'(t.we));
    chk({n, " be0"}, 32'(mem_byte_en), 32'(t.be0));
    chk({n, " wv0"}, mem_w_val, t.wv0);
    chk({n, " busy"}, {30'b0, req_ready, resp_valid}, 0);
    if (t.split) begin
      @(negedge clk);
      chk({n, " a1"}, 32'(mem_r_addr), 32'(t.a1));
      chk({n, " be1"}, 32'(mem_byte_en), 32'(t.be1));
      chk({n, " wv1"}, mem_w_val, t.wv1);
      chk({n, " busy2"}, {30'b0, req_ready, resp_valid}, 0);
    end
    @(negedge clk);
    chk({n, " resp"}, {30'b0, req_ready, resp_valid}, 1);
    chk({n, " rdata"}, resp_rdata, t.rdata);
    chk({n, " memidle"}, {mem_w_enable, mem_byte_en, 27'b0} | mem_w_val | 32'(mem_r_addr), 0);
    @(negedge clk);
    chk({n, " done"}, {30'b0, req_ready, resp_valid}, 2);
  endtask

  initial begin
    //      we addr          sz uns wdata         sp a0           a1     be0   be1   wv0           wv1           rdata
    v[0]  = '{0, 32'h103,     0, 0, 0,            0, 30'h40,       30'h0, 4'h0, 4'h0, 0,            0,            32'hFFFFFF80};
    v[1]  = '{0, 32'h103,     0, 1, 0,            0, 30'h40,       30'h0, 4'h0, 4'h0, 0,            0,            32'h00000080};
    v[2]  = '{1, 32'h102,     1, 0, 32'h1234,     0, 30'h40,       30'h0, 4'hC, 4'h0, 32'h12340000, 0,            0};
    v[3]  = '{0, 32'h100,     2, 0, 0,            0, 30'h40,       30'h0, 4'h0, 4'h0, 0,            0,            32'h1234BBCC};
    v[4]  = '{0, 32'h106,     2, 0, 0,            1, 30'h41,       30'h42, 4'h0, 4'h0, 0,           0,            32'h66554433};
    v[5]  = '{0, 32'hFFFFFFFF,1, 0, 0,            1, 30'h3FFFFFFF, 30'h0, 4'h0, 4'h0, 0,            0,            32'hFFFFCDAB};
    v[6]  = '{1, 32'h007,     2, 0, 32'hDEADBEEF, 1, 30'h1,        30'h2, 4'h8, 4'h7, 32'hEF000000, 32'h00DEADBE, 0};
    v[7]  = '{0, 32'h004,     2, 0, 0,            0, 30'h1,        30'h0, 4'h0, 4'h0, 0,            0,            32'hEF223344};
    v[8]  = '{0, 32'h008,     2, 0, 0,            0, 30'h2,        30'h0, 4'h0, 4'h0, 0,            0,            32'h55DEADBE};
    v[9]  = '{0, 32'h101,     1, 1, 0,            0, 30'h40,       30'h0, 4'h0, 4'h0, 0,            0,            32'h000034BB};
    v[10] = '{0, 32'h10A,     1, 0, 0,            0, 30'h42,       30'h0, 4'h0, 4'h0, 0,            0,            32'hFFFF8877};
    v[11] = '{1, 32'h109,     0, 0, 32'h5A,       0, 30'h42,       30'h0, 4'h2, 4'h0, 32'h00005A00, 0,            0};
    v[12] = '{0, 32'h109,     0, 1, 0,            0, 30'h42,       30'h0, 4'h0, 4'h0, 0,            0,            32'h0000005A};
    v[13] = '{0, 32'h10B,     0, 0, 0,            0, 30'h42,       30'h0, 4'h0, 4'h0, 0,            0,            32'hFFFFFF88};
    v[14] = '{0, 32'h100,     3, 1, 0,            0, 30'h40,       30'h0, 4'h0, 4'h0, 0,            0,            32'h1234BBCC};
    v[15] = '{0, 32'h108,     2, 1, 0,            0, 30'h42,       30'h0, 4'h0, 4'h0, 0,            0,            32'h88775A55};
    v[16] = '{0, 32'h00C,     2, 0, 0,            0, 30'h3,        30'h0, 4'h0, 4'h0, 0,            0,            32'hFEF00D11};
    v[17] = '{0, 32'h010,     2, 0, 0,            0, 30'h4,        30'h0, 4'h0, 4'h0, 0,            0,            32'h22222222};

    preload(30'h40, 32'h80AABBCC);
    preload(30'h41, 32'h44332211);
    preload(30'h42, 32'h88776655);
    preload(30'h3FFFFFFF, 32'hAB000000);
    preload(30'h0, 32'h000000CD);
    preload(30'h1, 32'h11223344);
    preload(30'h2, 32'h55667788);
    preload(30'h3, 32'h11111111);
    preload(30'h4, 32'h22222222);
    @(negedge clk);
    chk("reset outs", {req_ready, resp_valid, mem_w_enable, mem_byte_en, 25'b0} | resp_rdata | mem_w_val, 0);
    rst = 0;
    #1 chk("reset ready", 32'(req_ready), 1);

    for (int i = 0; i < 16; i++) run(v[i], $sformatf("v%0d", i));

    // split store 0xCAFEF00D at 0x00D, reset while the second word is on the bus
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h00D; req_size = 2; req_unsigned = 0; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("rst acc1 be", 32'(mem_byte_en), 32'hE);
    chk("rst acc1 wv", mem_w_val, 32'hFEF00D00);
    @(negedge clk);
    chk("rst acc2 a", 32'(mem_w_addr), 32'h4);
    chk("rst acc2 be", 32'(mem_byte_en), 32'h1);
    chk("rst acc2 wv", mem_w_val, 32'h000000CA);
    rst = 1;
    #1 chk("rst mid outs", {req_ready, resp_valid, mem_w_enable, mem_byte_en, 25'b0} | mem_w_val | 32'(mem_w_addr) | 32'(mem_r_addr), 0);
    @(negedge clk);
    rst = 0;
    #1 chk("rst release ready", 32'(req_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst no resp", 32'(resp_valid), 0);
    end
    run(v[16], "post rst w3");
    run(v[17], "post rst w4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the rv32i core's memory stage and the `ram` data port. Accepts one byte/halfword/word load or store request at a time, converts it into word-addressed RAM accesses with byte enables, and returns a sign- or zero-extended load result or a store-completion pulse. Accesses that cross a 32-bit word boundary are split into two consecutive RAM accesses by an internal state machine.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse for both loads and stores.
- `resp_rdata`  out  32  load result; 0 for stores.
- `mem_r_addr`  out  30  word address to the RAM read port.
- `mem_r_val`  in  32  combinational RAM read data.
- `mem_w_enable`  out  1  RAM write strobe.
- `mem_w_addr`  out  30  word address to the RAM write port.
- `mem_w_val`  out  32  lane-aligned write data.
- `mem_byte_en`  out  4  RAM byte-lane enables.

## Operation
- States: IDLE, ACC1, ACC2, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch we/addr/size/unsigned/wdata and go to ACC1.
- Derived from the latched request:
  - nbytes = 1/2/4.
  - off = addr[1:0].
  - mask8 = ((1<<nbytes)-1) << off (8 bits).
  - data64 = {32'b0, wdata} << (8*off).
  - split = mask8[7:4] != 0.
- ACC1: word address w0 = addr[31:2].
  - `mem_r_addr`=`mem_w_addr`=w0.
  - Store: `mem_w_enable`=1, `mem_byte_en`=mask8[3:0], `mem_w_val`=data64[31:0].
  - Load: capture `mem_r_val` into buffer low word.
  - Next state: ACC2 if split, else RESP.
- ACC2: word address w1 = w0+1, mod 2^30 (0x3FFFFFFF wraps to 0).
  - Store: `mem_byte_en`=mask8[7:4], `mem_w_val`=data64[63:32].
  - Load: capture buffer high word.
  - Next state: RESP.
- RESP: `resp_valid`=1.
  - Load: `resp_rdata` = (buffer64 >> 8*off) truncated to nbytes, then extended per `req_unsigned`.
  - Store: `resp_rdata`=0.
  - Next state: IDLE.
- Outside ACC states: `mem_w_enable`=0, `mem_byte_en`=0, `mem_w_val`=0, and both mem addresses = 0.
- Stores never read RAM. Loads never assert `mem_w_enable`.
- Word-size loads ignore `req_unsigned`.

## Timing
- Accept at edge T (IDLE with `req_valid`=1):
  - ACC1 during cycle T+1.
  - Non-split: `resp_valid` during cycle T+2.
  - Split: ACC2 during T+2, `resp_valid` during T+3.
- Store bytes are committed by the RAM at the rising edge that ends each ACC cycle. A load issued after a store's `resp_valid` observes the stored data.
- `resp_valid` has no backpressure and is high for exactly one cycle. `req_ready` is low from ACC1 through RESP. A request is accepted no earlier than the cycle after RESP.
- Request inputs are sampled only at acceptance; later changes have no effect.
- Reset, including mid-operation:
  - Immediate return to IDLE, buffer cleared.
  - All outputs go to 0 except `req_ready`, which is 1 once `rst` deasserts.
  - A split store reset during ACC2 has written only its first word.
  - No `resp_valid` is issued for an aborted request.

## Test plan
- Signed byte load: word 0x40 = 0x80AABBCC; lb at 0x103, `req_unsigned`=0 -> `mem_r_addr`=0x40 in ACC1; `resp_valid` 2 cycles after accept; `resp_rdata`=0xFFFFFF80. Same load with `req_unsigned`=1 -> 0x00000080.
- Halfword store: sh 0x00001234 at 0x102 -> one write to word 0x40, `mem_byte_en`=1100, `mem_w_val`=0x12340000; a subsequent lw at 0x100 of a word that was 0x80AABBCC returns 0x1234BBCC.
- Split word load: words 0x41=0x44332211, 0x42=0x88776655; lw at 0x106 -> `mem_r_addr` 0x41 then 0x42; `resp_rdata`=0x66554433; `resp_valid` 3 cycles after accept.
- Split word store: sw 0xDEADBEEF at 0x007 ->
  - word 1: `mem_byte_en`=1000, `mem_w_val`=0xEF000000.
  - then word 2: `mem_byte_en`=0111, `mem_w_val`=0x00DEADBE.
- Address wrap: lh at 0xFFFFFFFF with word 0x3FFFFFFF=0xAB000000 and word 0=0x000000CD, `req_unsigned`=0 -> accesses 0x3FFFFFFF then 0x00000000; `resp_rdata`=0xFFFFCDAB.
- Reset mid-store: assert `rst` during ACC2 of the split sw above -> only word 1 modified, no `resp_valid`, all mem outputs 0, `req_ready`=1 after release, next request completes normally.
